wb_stage: RTL and testbench

Parametrised writeback stage for the RISC-V core pipeline, between the memory stage and the register-file write port. It holds one retiring instruction and selects its result from PC, ALU or load data, plus CSR data when enabled. Load data is sign- or zero-extended per funct3 and byte offset. The block waits for a late memory response, supports pipeline flush, and drains an orphaned load response after a flush.

---
 rtl/wb_stage.sv | 190 +++++++++++++++++++
 tb/tb_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage between the memory stage and the register-file write port.
// Holds one retiring instruction and selects its result from PC, load, ALU or CSR data.
// Load data is formatted by funct3 and byte offset. A late load response is waited for.
// After a flush, a still-outstanding load response is drained.
// Optional feature macro: WB_CSR_SRC_EN (sel 11 writes the captured CSR data; else 0).
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_csr,
    input  logic [1:0]       in_sel,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_regwrite,
    input  logic [2:0]       in_funct3,
    input  logic [OFF_W-1:0] in_off,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             flush,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             err_spurious
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_CSR  = 2'b11;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   alu_q;
    logic [1:0]        sel_q;
    logic [RA_W-1:0]   rd_q;
    logic              regwrite_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic              rf_we_q;
    logic [RA_W-1:0]   rf_waddr_q;
    logic [XLEN-1:0]   rf_wdata_q;
    logic              err_q;
    logic [XLEN-1:0]   wdata_d;

    logic load_held;
    logic commit;
    logic capture;
    logic spurious;

`ifdef WB_CSR_SRC_EN
    logic [XLEN-1:0]   csr_q;
`else
    logic              unused_csr;
    assign unused_csr = ^in_csr;
`endif

    // Format a load response word: pick the addressed lane, then sign/zero extend.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [2:0]       f3,
        input logic [OFF_W-1:0] off,
        input logic [XLEN-1:0]  d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [XLEN-1:0] r;
        b = 8'(d >> {off, 3'b000});
        h = 16'(d >> {off & ~OFF_W'(1), 3'b000});
        w = 32'(d >> {off & ~OFF_W'(3), 3'b000});
        case (f3)
            3'b000:  r = XLEN'(signed'(b));
            3'b100:  r = XLEN'(b);
            3'b001:  r = XLEN'(signed'(h));
            3'b101:  r = XLEN'(h);
            3'b010:  r = XLEN'(signed'(w));
            3'b110:  r = XLEN'(w);
            default: r = d;
        endcase
        return r;
    endfunction

    // Handshake and commit qualifiers for the held entry.
    assign load_held = (state_q == S_HOLD) && (sel_q == SEL_LOAD);
    assign commit    = (state_q == S_HOLD) && !flush && (!load_held || mem_rvalid);
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && (commit || flush));
    assign capture   = in_valid && in_ready && !flush;
    assign spurious  = mem_rvalid &&
                       ((state_q == S_IDLE) || ((state_q == S_HOLD) && !load_held));

    // Result select for the held entry.
    always_comb begin
        wdata_d = '0;
        case (sel_q)
            SEL_PC:   wdata_d = pc_q;
            SEL_LOAD: wdata_d = fmt_load(funct3_q, off_q, mem_rdata);
            SEL_ALU:  wdata_d = alu_q;
            SEL_CSR: begin
`ifdef WB_CSR_SRC_EN
                wdata_d = csr_q;
`else
                wdata_d = '0;
`endif
            end
            default:  wdata_d = '0;
        endcase
    end

    // Entry capture on every accepted, unflushed instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            alu_q      <= '0;
            sel_q      <= SEL_PC;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
`ifdef WB_CSR_SRC_EN
            csr_q      <= '0;
`endif
        end else if (capture) begin
            pc_q       <= in_pc;
            alu_q      <= in_alu;
            sel_q      <= in_sel;
            rd_q       <= in_rd;
            regwrite_q <= in_regwrite;
            funct3_q   <= in_funct3;
            off_q      <= in_off;
`ifdef WB_CSR_SRC_EN
            csr_q      <= in_csr;
`endif
        end
    end

    // Stage FSM with registered register-file write port and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= commit && regwrite_q && (rd_q != '0);
            if (commit) begin
                rf_waddr_q <= rd_q;
                rf_wdata_q <= wdata_d;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (capture) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (flush) begin
                        state_q <= (load_held && !mem_rvalid) ? S_DRAIN : S_IDLE;
                    end else if (capture) begin
                        state_q <= S_HOLD;
                    end else if (commit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_rvalid) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OFF_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_alu;
    logic [XLEN-1:0]  in_csr;
    logic [1:0]       in_sel;
    logic [RA_W-1:0]  in_rd;
    logic             in_regwrite;
    logic [2:0]       in_funct3;
    logic [OFF_W-1:0] in_off;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    logic             flush;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             err_spurious;

    wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu(in_alu), .in_csr(in_csr),
        .in_sel(in_sel), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_funct3(in_funct3), .in_off(in_off),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: at most one held instruction, or one orphaned response owed.
    bit        m_full  = 1'b0;
    bit        m_drain = 1'b0;
    bit        chk_en  = 1'b0;
    bit [1:0]  e_sel;
    bit [4:0]  e_rd;
    bit        e_rw;
    bit [2:0]  e_f3;
    bit [1:0]  e_off;
    bit [31:0] e_pc, e_alu, e_csr;
    bit        x_we;
    bit [4:0]  x_waddr;
    bit [31:0] x_wdata;
    bit        x_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit [31:0] load_model(input bit [2:0] f3, input bit [1:0] off,
                                             input bit [31:0] d);
        bit [31:0] v;
        case (f3)
            3'd0: begin
                v = (d >> (8 * off)) & 32'hFF;
                if (v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'd4: v = (d >> (8 * off)) & 32'hFF;
            3'd1: begin
                v = (d >> (16 * (off / 2))) & 32'hFFFF;
                if (v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            3'd5: v = (d >> (16 * (off / 2))) & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic bit [31:0] csr_model(input bit [31:0] c);
`ifdef WB_CSR_SRC_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    function automatic bit [31:0] result_model();
        case (e_sel)
            2'd0:    return e_pc;
            2'd1:    return load_model(e_f3, e_off, mem_rdata);
            2'd2:    return e_alu;
            default: return csr_model(e_csr);
        endcase
    endfunction

    function automatic bit model_ready();
        return (!m_full && !m_drain) ||
               (m_full && (flush || e_sel != 2'd1 || mem_rvalid));
    endfunction

    task automatic model_update();
        bit idle, is_load, commit, ready;
        if (!rst_n) begin
            m_full = 0; m_drain = 0; x_we = 0; x_waddr = 0; x_wdata = 0; x_err = 0;
            chk_en = 1;
            return;
        end
        idle    = !m_full && !m_drain;
        is_load = m_full && e_sel == 2'd1;
        commit  = m_full && !flush && (!is_load || mem_rvalid);
        ready   = model_ready();
        if (mem_rvalid && (idle || (m_full && !is_load))) x_err = 1;
        x_we = commit && e_rw && e_rd != 0;
        if (commit) begin
            x_waddr = e_rd;
            x_wdata = result_model();
        end
        if (m_drain) begin
            if (mem_rvalid) m_drain = 0;
        end else if (m_full && flush) begin
            m_full  = 0;
            m_drain = is_load && !mem_rvalid;
        end else begin
            if (commit) m_full = 0;
            if (in_valid && ready && !flush) begin
                m_full = 1;
                e_sel = in_sel; e_rd = in_rd; e_rw = in_regwrite; e_f3 = in_funct3;
                e_off = in_off; e_pc = in_pc; e_alu = in_alu; e_csr = in_csr;
            end
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic model_compare();
        if (chk_en) begin
            check("in_ready",     32'(in_ready),     32'(model_ready()));
            check("rf_we",        32'(rf_we),        32'(x_we));
            check("rf_waddr",     32'(rf_waddr),     32'(x_waddr));
            check("rf_wdata",     rf_wdata,          x_wdata);
            check("err_spurious", 32'(err_spurious), 32'(x_err));
        end
    endtask

    // One clock cycle: compare mid-cycle, advance the model, then cross the edge.
    task automatic step();
        #4;
        model_compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; in_valid = 0; flush = 0; mem_rvalid = 0; mem_rdata = '0;
        in_sel = 2'd0; in_rd = '0; in_regwrite = 0; in_funct3 = '0; in_off = '0;
        in_pc = '0; in_alu = '0; in_csr = '0;
    endtask

    task automatic present(input bit [1:0] sel, input bit [4:0] rd, input bit [2:0] f3,
                           input bit [1:0] off, input bit [31:0] val);
        in_valid = 1; in_sel = sel; in_rd = rd; in_regwrite = 1; in_funct3 = f3;
        in_off = off; in_alu = val; in_pc = val; in_csr = val;
    endtask

    task automatic chk_ready(input string name, input bit exp);
        #1;
        check(name, 32'(in_ready), 32'(exp));
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1;
        check("reset_we",    32'(rf_we),        32'd0);
        check("reset_waddr", 32'(rf_waddr),     32'd0);
        check("reset_wdata", rf_wdata,          32'd0);
        check("reset_err",   32'(err_spurious), 32'd0);
        chk_ready("reset_ready", 1'b1);

        // Back-to-back ALU writes.
        present(2'd2, 5'd1, 3'd0, 2'd0, 32'h11); chk_ready("b2b_ready1", 1'b1); step();
        present(2'd2, 5'd2, 3'd0, 2'd0, 32'h22); chk_ready("b2b_ready2", 1'b1); step();
        check("b2b_we1", 32'(rf_we), 32'd1); check("b2b_x1", rf_wdata, 32'h11);
        check("b2b_a1", 32'(rf_waddr), 32'd1);
        present(2'd2, 5'd3, 3'd0, 2'd0, 32'h33); chk_ready("b2b_ready3", 1'b1); step();
        check("b2b_we2", 32'(rf_we), 32'd1); check("b2b_x2", rf_wdata, 32'h22);
        set_idle(); step();
        check("b2b_we3", 32'(rf_we), 32'd1); check("b2b_x3", rf_wdata, 32'h33);
        check("b2b_a3", 32'(rf_waddr), 32'd3);
        step();
        check("b2b_we_off", 32'(rf_we), 32'd0);

        // LB, offset 3, response three cycles late.
        present(2'd1, 5'd5, 3'd0, 2'd3, 32'h0); step();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            chk_ready("lb_wait_ready", 1'b0); step();
            check("lb_wait_we", 32'(rf_we), 32'd0);
        end
        mem_rvalid = 1; mem_rdata = 32'h80FF_0000; step();
        check("lb_we", 32'(rf_we), 32'd1); check("lb_data", rf_wdata, 32'hFFFF_FF80);
        set_idle(); step();

        // LHU then LH at offset 2 on the same word.
        present(2'd1, 5'd6, 3'd5, 2'd2, 32'h0); step();
        set_idle(); mem_rvalid = 1; mem_rdata = 32'h8001_1234;
        present(2'd1, 5'd7, 3'd1, 2'd2, 32'h0); chk_ready("lhu_ready", 1'b1); step();
        check("lhu_data", rf_wdata, 32'h0000_8001);
        set_idle(); mem_rvalid = 1; mem_rdata = 32'h8001_1234; step();
        check("lh_data", rf_wdata, 32'hFFFF_8001); check("lh_addr", 32'(rf_waddr), 32'd7);
        set_idle(); step();

        // rd = 0 write is suppressed; the following instruction still flows.
        present(2'd2, 5'd0, 3'd0, 2'd0, 32'h5); step();
        present(2'd2, 5'd7, 3'd0, 2'd0, 32'h77); chk_ready("x0_next_ready", 1'b1); step();
        check("x0_no_we", 32'(rf_we), 32'd0);
        set_idle(); step();
        check("x0_next_we", 32'(rf_we), 32'd1); check("x0_next_data", rf_wdata, 32'h77);

        // Flush with a load pending, then drain the orphaned response.
        present(2'd1, 5'd9, 3'd2, 2'd0, 32'h0); step();
        set_idle(); flush = 1; step();
        check("fl_we0", 32'(rf_we), 32'd0);
        set_idle(); present(2'd2, 5'd10, 3'd0, 2'd0, 32'hA0);
        chk_ready("drain_ready1", 1'b0); step();
        chk_ready("drain_ready2", 1'b0); step();
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        chk_ready("drain_ready3", 1'b0); step();
        check("drain_we", 32'(rf_we), 32'd0); check("drain_err", 32'(err_spurious), 32'd0);
        mem_rvalid = 0; chk_ready("drain_done_ready", 1'b1); step();
        set_idle(); step();
        check("post_drain_we", 32'(rf_we), 32'd1); check("post_drain_data", rf_wdata, 32'hA0);

        // Bare response in IDLE, then CSR source.
        set_idle(); mem_rvalid = 1; step();
        check("spurious_err", 32'(err_spurious), 32'd1);
        set_idle(); present(2'd3, 5'd4, 3'd0, 2'd0, 32'hABCD); step();
        set_idle(); step();
        check("csr_we", 32'(rf_we), 32'd1);
`ifdef WB_CSR_SRC_EN
        check("csr_data", rf_wdata, 32'hABCD);
`else
        check("csr_data", rf_wdata, 32'h0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_sel      = 2'($urandom_range(0, 3));
            in_rd       = 5'($urandom_range(0, 31));
            in_regwrite = ($urandom_range(0, 4) != 0);
            in_funct3   = 3'($urandom_range(0, 7));
            in_off      = 2'($urandom_range(0, 3));
            in_pc       = $urandom;
            in_alu      = $urandom;
            in_csr      = $urandom;
            mem_rvalid  = ($urandom_range(0, 9) < 3);
            mem_rdata   = $urandom;
            flush       = ($urandom_range(0, 99) < 8);
            step();
        end
        set_idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
